// File: rtl/flag_branch_unit.sv
// Architectural N/V/Z flag register, branch condition evaluation with optional
// same-cycle flag bypass, and saturating branch statistics counters.
module flag_branch_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       alu_flag,
    input  logic [2:0]       flag_we,
    input  logic             br_valid,
    input  logic [2:0]       br_ccc,
    output logic [2:0]       flags_q,
    output logic             br_taken,
    output logic [CNT_W-1:0] br_eval_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             upd;
    logic             br_upd;
    logic [2:0]       eff;
    logic [2:0]       flags_d;
    logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // f is {N,V,Z}
    function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (ccc)
            3'b000:  return ~z;
            3'b001:  return z;
            3'b010:  return ~z & ~n;
            3'b011:  return n;
            3'b100:  return z | (~z & ~n);
            3'b101:  return n | z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    assign upd    = ~stall & ~flush;
    // Reset also masks the combinational decision, not just the state update.
    assign br_upd = upd & ~rst;

    always_comb begin
        eff     = flags_q;
        flags_d = flags_q;
        for (int i = 0; i < 3; i++) begin
            if (upd && flag_we[i]) begin
                flags_d[i] = alu_flag[i];
                if (FWD_EN) eff[i] = alu_flag[i];
            end
        end
    end

    assign br_taken = br_valid & br_upd & cond_eval(br_ccc, eff);

    always_comb begin
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (br_valid && upd) begin
            eval_cnt_d = sat_inc(eval_cnt_q);
            if (br_taken) taken_cnt_d = sat_inc(taken_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= 3'b000;
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            flags_q     <= flags_d;
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_eval_cnt  = eval_cnt_q;
    assign br_taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: bypassing and non-bypassing instances side by side,
// compared against a flag/counter model built from the condition-code table.
module tb_flag_branch_unit;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(2**CNT_W - 1);

    logic             clk;
    logic             rst, stall, flush, br_valid;
    logic [2:0]       alu_flag, flag_we, br_ccc;
    logic [2:0]       fq1, fq0;
    logic             tk1, tk0;
    logic [CNT_W-1:0] ev1, ev0, tc1, tc0;

    logic [2:0]       m_flags;
    logic [CNT_W-1:0] m_ev1, m_ev0, m_tc1, m_tc0;

    int checks = 0;
    int errors = 0;

    flag_branch_unit #(.FWD_EN(1'b1), .CNT_W(CNT_W)) u_fwd (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .alu_flag(alu_flag), .flag_we(flag_we), .br_valid(br_valid), .br_ccc(br_ccc),
        .flags_q(fq1), .br_taken(tk1), .br_eval_cnt(ev1), .br_taken_cnt(tc1)
    );

    flag_branch_unit #(.FWD_EN(1'b0), .CNT_W(CNT_W)) u_nofwd (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .alu_flag(alu_flag), .flag_we(flag_we), .br_valid(br_valid), .br_ccc(br_ccc),
        .flags_q(fq0), .br_taken(tk0), .br_eval_cnt(ev0), .br_taken_cnt(tc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] msat(input logic [CNT_W-1:0] x);
        if (x == MAXV) return x;
        return x + CNT_W'(1);
    endfunction

    function automatic bit model_taken(input bit fwd);
        bit n, v, z;
        if (rst || stall || flush || !br_valid) return 1'b0;
        n = (fwd && flag_we[2]) ? alu_flag[2] : m_flags[2];
        v = (fwd && flag_we[1]) ? alu_flag[1] : m_flags[1];
        z = (fwd && flag_we[0]) ? alu_flag[0] : m_flags[0];
        case (br_ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input bit r, input bit s, input bit f, input logic [2:0] alu,
                         input logic [2:0] we, input bit bv, input logic [2:0] ccc);
        @(negedge clk);
        rst = r; stall = s; flush = f; alu_flag = alu; flag_we = we;
        br_valid = bv; br_ccc = ccc;
        #1;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic cycle();
        bit t1, t0;
        @(posedge clk);
        t1 = model_taken(1'b1);
        t0 = model_taken(1'b0);
        if (rst) begin
            m_flags = 3'b000;
            m_ev1 = '0; m_ev0 = '0; m_tc1 = '0; m_tc0 = '0;
        end else if (!stall && !flush) begin
            if (br_valid) begin
                m_ev1 = msat(m_ev1);
                m_ev0 = msat(m_ev0);
            end
            if (t1) m_tc1 = msat(m_tc1);
            if (t0) m_tc0 = msat(m_tc0);
            for (int i = 0; i < 3; i++)
                if (flag_we[i]) m_flags[i] = alu_flag[i];
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 3'b111, 3'b111, 1, 3'b111);
            checks++;
            if ({tk1, tk0} !== 2'b00) begin
                errors++;
                $display("FAIL reset_taken cyc%0d: got fwd=%b nofwd=%b want 0 0", k, tk1, tk0);
            end
            cycle();
        end
        checks++;
        if ({fq1, ev1, tc1, fq0, ev0, tc0} !== '0) begin
            errors++;
            $display("FAIL reset_state: got fq=%b/%b ev=%h/%h tc=%h/%h want all zero",
                     fq1, fq0, ev1, ev0, tc1, tc0);
        end
    endtask

    task automatic test_partial_write();
        drive(0, 0, 0, 3'b111, 3'b001, 0, 3'b000);
        cycle();
        checks++;
        if (fq1 !== 3'b001 || fq0 !== 3'b001 || m_flags !== 3'b001) begin
            errors++;
            $display("FAIL partial_we001: got %b/%b want 001", fq1, fq0);
        end
        drive(0, 0, 0, 3'b101, 3'b110, 0, 3'b000);
        cycle();
        checks++;
        if (fq1 !== 3'b101 || fq0 !== 3'b101) begin
            errors++;
            $display("FAIL partial_we110: got %b/%b want 101", fq1, fq0);
        end
    endtask

    task automatic test_cond_sweep();
        logic [2:0] fl [5];
        fl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        foreach (fl[j]) begin
            drive(0, 0, 0, fl[j], 3'b111, 0, 3'b000);
            cycle();
            for (int c = 0; c < 8; c++) begin
                drive(0, 0, 0, 3'b000, 3'b000, 1, 3'(c));
                checks++;
                if (tk1 !== model_taken(1'b1) || tk0 !== model_taken(1'b0)) begin
                    errors++;
                    $display("FAIL cond flags=%b ccc=%0d: got %b/%b want %b",
                             fl[j], c, tk1, tk0, model_taken(1'b1));
                end
                if (fl[j] == 3'b100 && (c == 3 || c == 2)) begin
                    checks++;
                    if (tk1 !== (c == 3)) begin
                        errors++;
                        $display("FAIL cond_N_lt_gt ccc=%0d: got %b want %b", c, tk1, (c == 3));
                    end
                end
                cycle();
            end
            checks++;
            if ({ev1, tc1, ev0, tc0} !== {m_ev1, m_tc1, m_ev0, m_tc0}) begin
                errors++;
                $display("FAIL sweep_cnt flags=%b: got ev=%h tc=%h want ev=%h tc=%h",
                         fl[j], ev1, tc1, m_ev1, m_tc1);
            end
        end
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 3'b000, 3'b111, 0, 3'b000);
        cycle();
        drive(0, 0, 0, 3'b001, 3'b111, 1, 3'b001);
        checks++;
        if (tk1 !== 1'b1 || tk0 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_taken: got fwd=%b nofwd=%b want 1 0", tk1, tk0);
        end
        cycle();
        checks++;
        if (fq1 !== 3'b001 || fq0 !== 3'b001) begin
            errors++;
            $display("FAIL bypass_flags: got %b/%b want 001", fq1, fq0);
        end
        checks++;
        if ({ev1, tc1, ev0, tc0} !== {m_ev1, m_tc1, m_ev0, m_tc0}) begin
            errors++;
            $display("FAIL bypass_cnt: got %h %h %h %h want %h %h %h %h",
                     ev1, tc1, ev0, tc0, m_ev1, m_tc1, m_ev0, m_tc0);
        end
    endtask

    task automatic test_stall_flush();
        logic [2:0]       f0;
        logic [CNT_W-1:0] e0, t0;
        for (int k = 0; k < 2; k++) begin
            f0 = fq1; e0 = ev1; t0 = tc1;
            drive(0, k == 0, k == 1, ~f0, 3'b111, 1, 3'b111);
            checks++;
            if ({tk1, tk0} !== 2'b00) begin
                errors++;
                $display("FAIL hold_taken %s: got %b/%b want 0", k ? "flush" : "stall", tk1, tk0);
            end
            cycle();
            checks++;
            if (fq1 !== f0 || ev1 !== e0 || tc1 !== t0 ||
                {fq0, ev0, tc0} !== {m_flags, m_ev0, m_tc0}) begin
                errors++;
                $display("FAIL hold_state %s: got fq=%b ev=%h tc=%h want fq=%b ev=%h tc=%h",
                         k ? "flush" : "stall", fq1, ev1, tc1, f0, e0, t0);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
                  3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
            checks++;
            if (tk1 !== model_taken(1'b1) || tk0 !== model_taken(1'b0)) begin
                errors++;
                $display("FAIL rand_taken it%0d: got %b/%b want %b/%b",
                         k, tk1, tk0, model_taken(1'b1), model_taken(1'b0));
            end
            cycle();
            checks++;
            if ({fq1, ev1, tc1, fq0, ev0, tc0} !== {m_flags, m_ev1, m_tc1, m_flags, m_ev0, m_tc0}) begin
                errors++;
                $display("FAIL rand_state it%0d: got fq=%b/%b ev=%h/%h tc=%h/%h want fq=%b ev=%h/%h tc=%h/%h",
                         k, fq1, fq0, ev1, ev0, tc1, tc0, m_flags, m_ev1, m_ev0, m_tc1, m_tc0);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 3'b000, 3'b000, 0, 3'b000);
        cycle();
        drive(0, 0, 0, 3'b000, 3'b000, 1, 3'b111);
        repeat (65535) cycle();
        checks++;
        if ({ev1, tc1, ev0, tc0} !== {4{16'hFFFF}}) begin
            errors++;
            $display("FAIL sat_preload: got %h %h %h %h want ffff", ev1, tc1, ev0, tc0);
        end
        cycle();
        checks++;
        if ({ev1, tc1, ev0, tc0} !== {4{16'hFFFF}}) begin
            errors++;
            $display("FAIL sat_hold: got %h %h %h %h want ffff", ev1, tc1, ev0, tc0);
        end
        drive(0, 0, 0, 3'b000, 3'b000, 1, 3'b110);
        checks++;
        if ({tk1, tk0} !== 2'b00) begin
            errors++;
            $display("FAIL sat_nottaken: got %b/%b want 0", tk1, tk0);
        end
        cycle();
        checks++;
        if ({ev1, tc1, ev0, tc0} !== {m_ev1, m_tc1, m_ev0, m_tc0} || ev1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_after_nt: got %h %h want ffff ffff", ev1, tc1);
        end
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; alu_flag = 0; flag_we = 0; br_valid = 0; br_ccc = 0;
        m_flags = 0; m_ev1 = 0; m_ev0 = 0; m_tc1 = 0; m_tc0 = 0;
        test_reset();
        test_partial_write();
        test_cond_sweep();
        test_bypass();
        test_stall_flush();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
